// File: rtl/mano_pkg.sv
// Shared constants for the basic computer control path: sequence counter width,
// opcode positions on the D decode bus and timing-step indices on T.
package mano_pkg;

  localparam int SC_W = 4;
  localparam int T_W  = 1 << SC_W;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_ADD    = 3'd1,
    OP_LDA    = 3'd2,
    OP_STA    = 3'd3,
    OP_BUN    = 3'd4,
    OP_BSA    = 3'd5,
    OP_ISZ    = 3'd6,
    OP_REG_IO = 3'd7
  } opcode_e;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
  localparam int T6 = 6;

endpackage

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with an enable; all outputs low when disabled.
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic [N-1:0]      sel_i,
  input  logic              en_i,
  output logic [2**N-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter, run/interrupt/IO flip-flops and the T/D decode for the controller.
// Outputs are registered state or decodes of it; only IR -> D is combinational.
module timing_sequencer #(
  parameter int SC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hlt,
  input  logic [15:0]        IR,
  input  logic               sc_clear,
  input  logic               ien_set,
  input  logic               ien_clear,
  input  logic               fgi_set,
  input  logic               fgi_clear,
  input  logic               fgo_set,
  input  logic               fgo_clear,
  output logic [2**SC_W-1:0] T,
  output logic [7:0]         D,
  output logic               I,
  output logic               R,
  output logic               S,
  output logic               IEN,
  output logic               FGI,
  output logic               FGO,
  output logic [SC_W-1:0]    sc
);
  import mano_pkg::*;

  logic [SC_W-1:0] sc_q, sc_d;
  logic s_q, s_d;
  logic r_q, r_d;
  logic ien_q, ien_d;
  logic i_q, i_d;
  logic fgi_q, fgi_d;
  logic fgo_q, fgo_d;
  logic past_t2;
  logic unused_ir;

  assign unused_ir = ^IR[11:0];

  onehot_decoder #(.N(SC_W)) u_t_dec (
    .sel_i    (sc_q),
    .en_i     (s_q),
    .onehot_o (T)
  );

  onehot_decoder #(.N(3)) u_d_dec (
    .sel_i    (IR[14:12]),
    .en_i     (1'b1),
    .onehot_o (D)
  );

  always_comb begin
    fgi_d   = fgi_set | (fgi_q & ~fgi_clear);
    fgo_d   = fgo_set | (fgo_q & ~fgo_clear);
    ien_d   = ~ien_clear & (ien_set | ien_q);
    s_d     = ~hlt & (start | s_q);
    i_d     = (T[T2] && !r_q) ? IR[15] : i_q;
    past_t2 = s_q && (sc_q > SC_W'(T2));

    // A halted counter keeps its step until the next start restarts it at T0.
    sc_d = sc_q;
    if (!s_q) begin
      if (s_d) sc_d = '0;
    end else if (sc_clear) begin
      sc_d = '0;
    end else if (!hlt) begin
      sc_d = sc_q + 1'b1;
    end

    // Flag edges seen this cycle count, so an interrupt raised at Tk is visible next edge.
    r_d = r_q;
    if (sc_clear && r_q)                          r_d = 1'b0;
    else if (past_t2 && ien_q && (fgi_d | fgo_d)) r_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc_q  <= '0;
      s_q   <= 1'b0;
      r_q   <= 1'b0;
      ien_q <= 1'b0;
      i_q   <= 1'b0;
      fgi_q <= 1'b0;
      fgo_q <= 1'b1;
    end else begin
      sc_q  <= sc_d;
      s_q   <= s_d;
      r_q   <= r_d;
      ien_q <= ien_d;
      i_q   <= i_d;
      fgi_q <= fgi_d;
      fgo_q <= fgo_d;
    end
  end

  assign sc  = sc_q;
  assign S   = s_q;
  assign R   = r_q;
  assign IEN = ien_q;
  assign I   = i_q;
  assign FGI = fgi_q;
  assign FGO = fgo_q;

endmodule
